// File: rtl/sysbus_mem_responder.sv
// -----------------------------------------------------------------------------
// sysbus_mem_responder
//
// Memory-side target of the system bus. Accepts line-sized (8 x 64-bit beat)
// read and write requests from cache initiators and serves them from a backing
// word array. It replaces the external memory model in block-level and
// core-level simulation.
//
// Handshake summary:
//   Request channel:
//     bus_reqcyc/bus_req/bus_reqtag carry a header while the FSM is idle.
//     bus_reqack pulses for exactly one cycle, the cycle after the header is
//     taken. In the write-data phase, every later cycle with bus_reqcyc=1
//     carries one data beat.
//   Response channel:
//     A beat transfers on every clock edge where bus_respcyc && bus_respack
//     are both high. While bus_respack=0 the beat is held stable.
//     bus_respack is ignored while bus_respcyc=0.
//
// Ports:
//   clk          in   clock, all logic on posedge
//   reset        in   synchronous, active-high reset
//   bus_reqcyc   in   request valid (header, or write beat in WDATA)
//   bus_req      in   request address (header) or write data (beats)
//   bus_reqtag   in   request tag: bit 12 = memory space, [11:8] = command
//   bus_reqack   out  one-cycle header accept pulse
//   bus_respcyc  out  read beat valid
//   bus_respack  in   initiator accepts the current beat
//   bus_resp     out  read beat data
//   bus_resptag  out  echo of the accepted request tag
//   dbg_state    out  current FSM state (IDLE=0, WDATA=1, RLAT=2, RBURST=3)
//
// Configuration macro:
//   SYSBUS_RESP_WRITE_EN  defined   -> write beats are stored into the array
//                         undefined -> write beats are consumed and discarded
//                                      (the array is read-only)
// -----------------------------------------------------------------------------
module sysbus_mem_responder #(
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int MEM_WORDS      = 65536,
    parameter int LATENCY        = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    input  logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic [1:0]                dbg_state
);

    // Bus command encodings carried in bus_reqtag.
    localparam logic [3:0] SYSBUS_READ   = 4'h1;
    localparam logic [3:0] SYSBUS_WRITE  = 4'h2;
    localparam logic       SYSBUS_MEMORY = 1'b1;

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(LATENCY + 1);
    localparam int LW = BUS_DATA_WIDTH - 6;   // line address width, A[63:6]

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WDATA  = 2'd1,
        S_RLAT   = 2'd2,
        S_RBURST = 2'd3
    } state_t;

    state_t                    r_state;
    logic [LW-1:0]             r_line;      // latched A[63:6]
    logic [2:0]                r_b;         // beat index within the line
    logic [2:0]                r_cnt;       // beats transferred so far
    logic [CW-1:0]             r_lat;       // read latency countdown
    logic                      r_reqack;
    logic                      r_respcyc;
    logic [BUS_DATA_WIDTH-1:0] r_resp;
    logic [BUS_TAG_WIDTH-1:0]  r_resptag;

    logic [BUS_DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    logic [LW+2:0]             w_word_full;
    logic [LW+2:0]             w_word_nxt_full;
    logic [AW-1:0]             w_word;
    logic [AW-1:0]             w_word_nxt;
    logic                      w_is_mem;
    logic [3:0]                w_cmd;
    logic                      w_hdr_read;
    logic                      w_hdr_write;
    logic                      w_wbeat;
    logic                      w_unused;

    // Word index = {A[63:6], b} modulo the array depth; the upper address bits
    // simply fall off.
    assign w_word_full     = {r_line, r_b};
    assign w_word_nxt_full = {r_line, r_b + 3'd1};
    assign w_word          = w_word_full[AW-1:0];
    assign w_word_nxt      = w_word_nxt_full[AW-1:0];

    assign w_is_mem    = (bus_reqtag[12] == SYSBUS_MEMORY);
    assign w_cmd       = bus_reqtag[11:8];
    assign w_hdr_read  = bus_reqcyc && w_is_mem && (w_cmd == SYSBUS_READ);
    assign w_hdr_write = bus_reqcyc && w_is_mem && (w_cmd == SYSBUS_WRITE);

    // The initiator keeps the header on the bus during the reqack cycle, so
    // the first WDATA cycle (r_reqack still high) never counts as a beat.
    assign w_wbeat = (r_state == S_WDATA) && bus_reqcyc && !r_reqack;

    // Address bits above the array depth and the byte offset are don't-care.
    assign w_unused = ^{w_word_full[LW+2:AW], w_word_nxt_full[LW+2:AW], bus_req[2:0]};

    assign bus_reqack  = r_reqack;
    assign bus_respcyc = r_respcyc;
    assign bus_resp    = r_resp;
    assign bus_resptag = r_resptag;
    assign dbg_state   = r_state;

    // Backing array. Never reset: contents come from an external preload
    // or from bus writes. A write landing on a reset edge is dropped.
`ifdef SYSBUS_RESP_WRITE_EN
    always_ff @(posedge clk) begin
        if (!reset && w_wbeat) begin
            r_mem[w_word] <= bus_req;
        end
    end
`else
    // Read-only build: the write port rewrites the word it already holds, so
    // write beats are consumed but their data is discarded.
    always_ff @(posedge clk) begin
        if (!reset && w_wbeat) begin
            r_mem[w_word] <= r_mem[w_word];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_line    <= '0;
            r_b       <= 3'd0;
            r_cnt     <= 3'd0;
            r_lat     <= '0;
            r_reqack  <= 1'b0;
            r_respcyc <= 1'b0;
            r_resp    <= '0;
            r_resptag <= '0;
        end else begin
            r_reqack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_hdr_read || w_hdr_write) begin
                        r_line    <= bus_req[BUS_DATA_WIDTH-1:6];
                        r_b       <= bus_req[5:3];
                        r_cnt     <= 3'd0;
                        r_resptag <= bus_reqtag;
                        r_reqack  <= 1'b1;
                        if (w_hdr_read) begin
                            r_state <= S_RLAT;
                            r_lat   <= CW'(LATENCY);
                        end else begin
                            r_state <= S_WDATA;
                        end
                    end
                end

                S_WDATA: begin
                    if (w_wbeat) begin
                        r_b   <= r_b + 3'd1;
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                S_RLAT: begin
                    // The counter reaches zero on the edge that presents beat 0,
                    // giving exactly LATENCY cycles after the reqack cycle.
                    r_lat <= r_lat - 1'b1;
                    if (r_lat <= CW'(1)) begin
                        r_lat     <= '0;
                        r_state   <= S_RBURST;
                        r_respcyc <= 1'b1;
                        r_resp    <= r_mem[w_word];
                    end
                end

                S_RBURST: begin
                    if (r_respcyc && bus_respack) begin
                        r_b   <= r_b + 3'd1;
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            r_respcyc <= 1'b0;
                            r_resp    <= '0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_resp <= r_mem[w_word_nxt];
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_sysbus_mem_responder
//
// Directed bench for sysbus_mem_responder. A table of line transactions
// (reads with expected beats, writes with data) is applied in order, followed
// by hand-written sequences for idle behaviour, foreign/unknown tags and reset
// in the middle of a burst. Expected values are hand-derived from the
// preloaded array contents and the critical-word-first beat order.
// -----------------------------------------------------------------------------
module tb_sysbus_mem_responder;

    localparam int LAT = 4;

    localparam logic [12:0] TAG_RD          = 13'h1100;  // memory space, READ
    localparam logic [12:0] TAG_WR          = 13'h1200;  // memory space, WRITE
    localparam logic [12:0] TAG_OTHER_SPACE = 13'h0100;  // READ, not memory
    localparam logic [12:0] TAG_BAD_CMD     = 13'h1f00;  // memory, unknown cmd

    logic        clk;
    logic        reset;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic        bus_respack;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit               is_write;
        logic [63:0]      addr;
        int               ack_mode;   // 0: respack held 1, 1: pattern 1,0,0,...
        logic [7:0][63:0] val;        // expected beats (read) or data (write)
    } vec_t;

    vec_t vecs[8];

    sysbus_mem_responder #(
        .BUS_TAG_WIDTH (13),
        .BUS_DATA_WIDTH(64),
        .MEM_WORDS     (65536),
        .LATENCY       (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_reqcyc (bus_reqcyc),
        .bus_req    (bus_req),
        .bus_reqtag (bus_reqtag),
        .bus_reqack (bus_reqack),
        .bus_respcyc(bus_respcyc),
        .bus_respack(bus_respack),
        .bus_resp   (bus_resp),
        .bus_resptag(bus_resptag),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Line contents where word k holds base + ((start + k) mod 8).
    function automatic logic [7:0][63:0] line_from(input logic [63:0] base, input int start);
        logic [7:0][63:0] r;
        for (int k = 0; k < 8; k++) r[k] = base + 64'((start + k) % 8);
        return r;
    endfunction

    // ---------------- drivers ----------------
    task automatic do_read(input logic [63:0] addr, input int mode,
                           input logic [7:0][63:0] exp, input bit timed);
        int  n;
        int  beats;
        int  k;
        bit  first;
        bit  ack;
        @(negedge clk);
        bus_reqcyc  = 1'b1;
        bus_req     = addr;
        bus_reqtag  = TAG_RD;
        bus_respack = (mode == 0);
        @(negedge clk);
        n = 1;
        check("read_reqack", 64'(bus_reqack), 64'd1);
        beats = 0;
        k     = 0;
        first = 1'b1;
        while (beats < 8 && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 2) begin
                check("read_reqack_pulse", 64'(bus_reqack), 64'd0);
                bus_reqcyc = 1'b0;
            end
            if (bus_respcyc) begin
                if (first) begin
                    first = 1'b0;
                    if (timed) check("read_first_beat_cycle", 64'(n), 64'(1 + LAT));
                    check("read_resptag", 64'(bus_resptag), 64'(TAG_RD));
                end
                ack = (mode == 0) ? 1'b1 : (k % 3 == 0);
                k++;
                bus_respack = ack;
                check($sformatf("read_beat%0d", beats), bus_resp, exp[beats]);
                if (ack) beats++;
            end else begin
                bus_respack = (mode == 0);
            end
        end
        if (beats < 8) begin
            check("read_beats_timeout", 64'(beats), 64'd8);
        end else begin
            @(negedge clk);
            n++;
            check("read_respcyc_end", 64'(bus_respcyc), 64'd0);
            if (timed) check("read_end_cycle", 64'(n), 64'(9 + LAT));
        end
        bus_respack = 1'b0;
    endtask

    // Write with bubble cycles at slots 2 and 6 of the data phase.
    task automatic do_write(input logic [63:0] addr, input logic [7:0][63:0] data);
        int sent;
        int slot;
        @(negedge clk);
        bus_reqcyc = 1'b1;
        bus_req    = addr;
        bus_reqtag = TAG_WR;
        @(negedge clk);
        check("write_reqack", 64'(bus_reqack), 64'd1);
        sent = 0;
        slot = 0;
        while (sent < 8 && slot < 20) begin
            @(negedge clk);
            if (slot == 0) check("write_reqack_pulse", 64'(bus_reqack), 64'd0);
            check("write_no_resp", 64'(bus_respcyc), 64'd0);
            if (slot == 2 || slot == 6) begin
                bus_reqcyc = 1'b0;
            end else begin
                bus_reqcyc = 1'b1;
                bus_req    = data[sent];
                sent++;
            end
            slot++;
        end
        @(negedge clk);
        bus_reqcyc = 1'b0;
        check("write_done_idle", 64'(dbg_state), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int  beats;
        bit  rst_done;

        reset       = 1'b1;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;

        // Preload: line 0x1000 and line 0x2000.
        for (int i = 0; i < 8; i++) begin
            dut.r_mem[32'h200 + i] = 64'h1111_0000 + 64'(i);
            dut.r_mem[32'h400 + i] = 64'h2222_0000 + 64'(i);
        end

        // Transaction table.
        vecs[0] = '{1'b0, 64'h1000,        0, line_from(64'h1111_0000, 0)};
        vecs[1] = '{1'b0, 64'h1030,        0, line_from(64'h1111_0000, 6)};
        vecs[2] = '{1'b0, 64'h1008,        1, line_from(64'h1111_0000, 1)};
        vecs[3] = '{1'b0, 64'h1_0000_1010, 0, line_from(64'h1111_0000, 2)};
        vecs[4] = '{1'b1, 64'h2000,        0, line_from(64'hA0, 0)};
        vecs[6] = '{1'b1, 64'h2028,        0, line_from(64'hB0, 0)};
`ifdef SYSBUS_RESP_WRITE_EN
        vecs[5] = '{1'b0, 64'h2000,        0, line_from(64'hA0, 0)};
        vecs[7] = '{1'b0, 64'h2000,        1, line_from(64'hB0, 3)};
`else
        vecs[5] = '{1'b0, 64'h2000,        0, line_from(64'h2222_0000, 0)};
        vecs[7] = '{1'b0, 64'h2000,        1, line_from(64'h2222_0000, 0)};
`endif

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state, then idle for 10 cycles with respack held high.
        bus_respack = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_reqack",  64'(bus_reqack),  64'd0);
            check("idle_respcyc", 64'(bus_respcyc), 64'd0);
            check("idle_resp",    bus_resp,         64'd0);
            check("idle_resptag", 64'(bus_resptag), 64'd0);
            check("idle_state",   64'(dbg_state),   64'd0);
        end
        bus_respack = 1'b0;

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is_write) do_write(vecs[i].addr, vecs[i].val);
            else do_read(vecs[i].addr, vecs[i].ack_mode, vecs[i].val, vecs[i].ack_mode == 0);
        end

        // Foreign-space header, then unknown command: never acknowledged.
        @(negedge clk);
        bus_reqcyc = 1'b1;
        bus_req    = 64'h1000;
        bus_reqtag = TAG_OTHER_SPACE;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("foreign_no_reqack", 64'(bus_reqack),  64'd0);
            check("foreign_no_resp",   64'(bus_respcyc), 64'd0);
        end
        bus_reqtag = TAG_BAD_CMD;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("badcmd_no_reqack", 64'(bus_reqack), 64'd0);
            check("badcmd_state",     64'(dbg_state),  64'd0);
        end
        bus_reqcyc = 1'b0;

        // Reset while beat 3 of a read is on the bus.
        @(negedge clk);
        bus_reqcyc  = 1'b1;
        bus_req     = 64'h1000;
        bus_reqtag  = TAG_RD;
        bus_respack = 1'b1;
        beats    = 0;
        rst_done = 1'b0;
        for (int c = 0; c < 60 && !rst_done; c++) begin
            @(negedge clk);
            if (c == 1) bus_reqcyc = 1'b0;
            if (bus_respcyc) begin
                if (beats == 3) begin
                    check("rst_beat3", bus_resp, 64'h1111_0003);
                    reset    = 1'b1;
                    rst_done = 1'b1;
                end else begin
                    beats++;
                end
            end
        end
        if (!rst_done) begin
            check("rst_seq_timeout", 64'(beats), 64'd3);
        end else begin
            @(negedge clk);
            check("rst_respcyc", 64'(bus_respcyc), 64'd0);
            check("rst_resp",    bus_resp,         64'd0);
            check("rst_resptag", 64'(bus_resptag), 64'd0);
            check("rst_state",   64'(dbg_state),   64'd0);
        end
        reset       = 1'b0;
        bus_respack = 1'b0;
        bus_reqcyc  = 1'b0;

        // A fresh read after the abort completes normally.
        do_read(64'h1000, 0, line_from(64'h1111_0000, 0), 1'b1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
